// File: rtl/i2s_stereo_core.sv
// i2s_stereo_core: slave-mode I2S stereo transceiver with a TX frame FIFO.
// Ports: clk_i/rst_i system clock and async active-high reset; bypass_i routes i2s_data_i
// straight to i2s_data_o; i2s_sclk_i/i2s_lrclk_i/i2s_data_i external bus (LRCLK low = left);
// i2s_data_o serial TX; tx_data_i/tx_val_i/tx_ready_o {left,right} frame write port;
// rx_left_o/rx_right_o/rx_val_o received frame; tx_underrun_o/rx_overrun_o error strobes.
module i2s_stereo_core #(
  parameter int DATA_WIDTH = 24,
  parameter int BUFFERS_AWIDTH = 4,
  parameter int I2S_FORMAT = 0,
  parameter logic [1:0] CHANNEL_MASK = 2'b11
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    bypass_i,
  input  logic                    i2s_sclk_i,
  input  logic                    i2s_lrclk_i,
  input  logic                    i2s_data_i,
  output logic                    i2s_data_o,
  input  logic [2*DATA_WIDTH-1:0] tx_data_i,
  input  logic                    tx_val_i,
  output logic                    tx_ready_o,
  output logic [DATA_WIDTH-1:0]   rx_left_o,
  output logic [DATA_WIDTH-1:0]   rx_right_o,
  output logic                    rx_val_o,
  output logic                    tx_underrun_o,
  output logic                    rx_overrun_o
);
  localparam int DW = DATA_WIDTH;
  localparam int AW = BUFFERS_AWIDTH;
  localparam logic [5:0] FB = 6'(I2S_FORMAT);
  localparam logic [5:0] DWV = 6'(DW);
  localparam logic [5:0] DWM1 = 6'(DW - 1);
  typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;
  state_t state_q, state_d;
  logic [1:0] sclk_q, lr_q, dat_q;
  logic sclk_p_q, lr_p_q, data_q;
  logic [5:0] cnt_q, cnt_d, tx_pos, tx_sh, rx_pos, rx_sh;
  logic [DW-1:0] sr_q, lhold_q, tx_word, tx_bits, rx_set;
  logic [2*DW-1:0] shadow_q, shadow_d;
  logic [2*DW-1:0] mem_q [2**AW];
  logic [AW:0] wptr_q, rptr_q;
  logic sclk_rise, sclk_fall, lr_edge, lr_fall, lr_rise, ovf, empty, full, wr, pop, rd, tx_bit;
  assign sclk_rise = sclk_q[1] & ~sclk_p_q;
  assign sclk_fall = ~sclk_q[1] & sclk_p_q;
  assign lr_edge = lr_q[1] ^ lr_p_q;
  assign lr_fall = lr_edge & ~lr_q[1];
  assign lr_rise = lr_edge & lr_q[1];
  // a 33rd SCLK in one slot means the LRCLK edge was missed
  assign ovf = sclk_rise & ~lr_edge & (cnt_q == 6'd32) & (state_q != IDLE);
  assign empty = wptr_q == rptr_q;
  assign full = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign tx_ready_o = ~full;
  assign wr = tx_val_i & ~full;
  assign pop = lr_fall & (state_q != LEFT);
  assign rd = pop & ~empty;
  assign i2s_data_o = bypass_i ? i2s_data_i : data_q;
  // TX uses the post-edge state so the first slot bit leaves on the same SCLK fall as LRCLK
  always_comb begin
    state_d = lr_fall ? LEFT : (lr_rise && state_q == LEFT) ? RIGHT : ovf ? IDLE : state_q;
    cnt_d = lr_edge ? 6'd0 : (sclk_rise && cnt_q != 6'd32) ? cnt_q + 6'd1 : cnt_q;
    shadow_d = !pop ? shadow_q : empty ? '0 : mem_q[rptr_q[AW-1:0]];
    tx_word = (state_d == LEFT && CHANNEL_MASK[0]) ? shadow_d[2*DW-1:DW] :
              (state_d == RIGHT && CHANNEL_MASK[1]) ? shadow_d[DW-1:0] : '0;
    tx_pos = cnt_d - FB;
    tx_sh = DWM1 - tx_pos;
    tx_bits = tx_word >> tx_sh;
    tx_bit = (tx_pos < DWV) & tx_bits[0];
    rx_pos = cnt_q - FB;
    rx_sh = DWM1 - rx_pos;
    rx_set = (rx_pos < DWV) ? {{(DW-1){1'b0}}, dat_q[1]} << rx_sh : '0;
  end
  always_ff @(posedge clk_i) if (wr) mem_q[wptr_q[AW-1:0]] <= tx_data_i;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      sclk_q <= '0;
      lr_q <= '0;
      dat_q <= '0;
      sclk_p_q <= 1'b0;
      lr_p_q <= 1'b0;
      state_q <= IDLE;
      cnt_q <= '0;
      shadow_q <= '0;
      sr_q <= '0;
      lhold_q <= '0;
      rx_left_o <= '0;
      rx_right_o <= '0;
      rx_val_o <= 1'b0;
      tx_underrun_o <= 1'b0;
      rx_overrun_o <= 1'b0;
      data_q <= 1'b0;
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      sclk_q <= {sclk_q[0], i2s_sclk_i};
      lr_q <= {lr_q[0], i2s_lrclk_i};
      dat_q <= {dat_q[0], i2s_data_i};
      sclk_p_q <= sclk_q[1];
      lr_p_q <= lr_q[1];
      state_q <= state_d;
      cnt_q <= cnt_d;
      shadow_q <= shadow_d;
      // slot register starts cleared, so a short slot leaves its missing LSBs at zero
      sr_q <= lr_edge ? '0 : (sclk_rise && state_q != IDLE) ? sr_q | rx_set : sr_q;
      if (lr_rise && state_q == LEFT) lhold_q <= sr_q;
      rx_val_o <= lr_fall && state_q == RIGHT;
      if (lr_fall && state_q == RIGHT) begin
        rx_left_o <= CHANNEL_MASK[0] ? lhold_q : '0;
        rx_right_o <= CHANNEL_MASK[1] ? sr_q : '0;
      end
      tx_underrun_o <= pop & empty;
      rx_overrun_o <= ovf;
      if (sclk_fall) data_q <= tx_bit;
      if (wr) wptr_q <= wptr_q + 1'b1;
      if (rd) rptr_q <= rptr_q + 1'b1;
    end
endmodule

// File: tb/tb_i2s_stereo_core.sv
// tb_i2s_stereo_core: directed checks of loopback, formats, FIFO, slot errors, reset and bypass.
module tb_i2s_stereo_core;
  logic clk = 0, rst = 1, sclk = 0, lrclk = 0, bdat = 0, bypass = 0, loop = 0, lb = 0;
  logic [47:0] tx0 = '0;
  logic [31:0] tx1 = '0;
  logic v0 = 0, v1 = 0;
  logic u0_do, u0_rdy, u0_val, u0_und, u0_ovr, u1_do, u1_rdy, u1_val, u1_und, u1_ovr;
  logic [23:0] u0_rl, u0_rr;
  logic [15:0] u1_rl, u1_rr;
  int errors = 0, checks = 0, nval0 = 0, nund0 = 0, novr0 = 0, novr1 = 0, nz = 0, bidx = 0;
  int v, u, o, o1;
  logic ob1 [64];
  logic [15:0] p;
  logic e;
  logic [31:0] bl [3], br [3];
  typedef struct { logic [23:0] tl, tr, el, er; } vec_t;
  vec_t tab [4];

  always #5 clk = ~clk;
  always @(posedge clk) begin
    lb <= u0_do;
    if (u0_val) nval0++;
    if (u0_und) nund0++;
    if (u0_ovr) novr0++;
    if (u1_ovr) novr1++;
  end

  i2s_stereo_core u0 (
    .clk_i(clk), .rst_i(rst), .bypass_i(bypass), .i2s_sclk_i(sclk), .i2s_lrclk_i(lrclk),
    .i2s_data_i(loop ? lb : bdat), .i2s_data_o(u0_do), .tx_data_i(tx0), .tx_val_i(v0),
    .tx_ready_o(u0_rdy), .rx_left_o(u0_rl), .rx_right_o(u0_rr), .rx_val_o(u0_val),
    .tx_underrun_o(u0_und), .rx_overrun_o(u0_ovr));

  i2s_stereo_core #(.DATA_WIDTH(16), .I2S_FORMAT(1)) u1 (
    .clk_i(clk), .rst_i(rst), .bypass_i(1'b0), .i2s_sclk_i(sclk), .i2s_lrclk_i(lrclk),
    .i2s_data_i(bdat), .i2s_data_o(u1_do), .tx_data_i(tx1), .tx_val_i(v1),
    .tx_ready_o(u1_rdy), .rx_left_o(u1_rl), .rx_right_o(u1_rr), .rx_val_o(u1_val),
    .tx_underrun_o(u1_und), .rx_overrun_o(u1_ovr));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic sel, input logic [47:0] d);
    @(posedge clk); #2;
    if (sel) begin tx1 = d[31:0]; v1 = 1; end else begin tx0 = d; v0 = 1; end
    @(posedge clk); #2;
    v0 = 0; v1 = 0;
  endtask

  // one SCLK period: LRCLK and data change on the falling edge, outputs sampled just before the rise
  task automatic sbit(input logic lr, input logic d);
    sclk = 0; lrclk = lr; bdat = d;
    #1;
    if (bypass) chk("bypass_follow", 32'(u0_do), 32'(bdat));
    #78;
    if (bidx < 64) begin ob1[bidx] = u1_do; bidx++; end
    if (u0_do) nz++;
    #1 sclk = 1;
    #80;
  endtask

  task automatic half(input logic lr, input logic [31:0] w, input int n);
    logic [31:0] s = w;
    for (int i = 0; i < n; i++) begin
      sbit(lr, s[31]);
      s = s << 1;
    end
  endtask

  task automatic frame(input logic [31:0] l, input logic [31:0] r, input int n);
    bidx = 0;
    half(0, l, n);
    half(1, r, n);
  endtask

  initial begin
    tab[0] = '{24'h800001, 24'h7FFFFE, 24'h800001, 24'h7FFFFE};
    tab[1] = '{24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'h000000};
    tab[2] = '{24'h123456, 24'hABCDEF, 24'h123456, 24'hABCDEF};
    tab[3] = '{24'hA5A5A5, 24'h5A5A5A, 24'hA5A5A5, 24'h5A5A5A};
    #32;
    chk("rst_left", 32'(u0_rl), 0);
    chk("rst_right", 32'(u0_rr), 0);
    chk("rst_val", 32'(u0_val), 0);
    chk("rst_und", 32'(u0_und), 0);
    chk("rst_ovr", 32'(u0_ovr), 0);
    chk("rst_dout", 32'(u0_do), 0);
    chk("rst_ready", 32'(u0_rdy), 1);
    @(posedge clk); #2 rst = 0;
    for (int k = 0; k < 4; k++) push(0, {tab[k].tl, tab[k].tr});
    push(1, {16'h0, 16'hA5A5, 16'h0000});
    loop = 1;
    half(1, 0, 2);
    for (int k = 0; k < 5; k++) begin
      frame(0, 0, 32);
      if (k == 0) begin
        p = 16'hA5A5;
        for (int i = 0; i < 18; i++) begin
          e = (i >= 1 && i <= 16) ? p[15] : 1'b0;
          if (i >= 1) p = p << 1;
          chk("fmt1_bit", 32'(ob1[i]), 32'(e));
        end
      end else begin
        chk("loop_left", 32'(u0_rl), 32'(tab[k-1].el));
        chk("loop_right", 32'(u0_rr), 32'(tab[k-1].er));
        chk("loop_vals", 32'(nval0), 32'(k));
      end
    end
    loop = 0;
    u = nund0; nz = 0;
    for (int k = 0; k < 3; k++) frame(0, 0, 32);
    chk("und_count", 32'(nund0 - u), 3);
    chk("und_zero_out", 32'(nz), 0);
    for (int i = 0; i < 16; i++) begin
      push(0, {24'(i), 24'(~i)});
      chk("fifo_ready", 32'(u0_rdy), 32'(i != 15));
    end
    for (int k = 0; k < 3; k++) frame(32'hFFF00000, 32'hABC00000, 12);
    chk("short_left", 32'(u0_rl), 32'hFFF000);
    chk("short_right", 32'(u0_rr), 32'hABC000);
    chk("short_left_i2s", 32'(u1_rl), 32'hFFE0);
    chk("short_right_i2s", 32'(u1_rr), 32'h5780);
    o = novr0; o1 = novr1;
    half(0, 0, 40);
    v = nval0;
    chk("ovr_count", 32'(novr0 - o), 1);
    chk("ovr_count_i2s", 32'(novr1 - o1), 1);
    half(1, 0, 12);
    half(0, 0, 12);
    chk("ovr_idle_noval", 32'(nval0 - v), 0);
    half(1, 0, 12);
    frame(32'h13579B00, 32'h2468AC00, 32);
    half(0, 32'hCAFE1200, 32);
    half(1, 32'hBEEF0000, 10);
    chk("pre_rst_left", 32'(u0_rl), 32'h13579B);
    rst = 1;
    #1;
    chk("async_rst_left", 32'(u0_rl), 0);
    chk("async_rst_right", 32'(u0_rr), 0);
    chk("async_rst_dout", 32'(u0_do), 0);
    #20 rst = 0;
    v = nval0; u = nund0;
    half(1, 0, 22);
    frame(32'h0F1E2D00, 32'h3C4B5A00, 32);
    frame(32'h11223300, 32'h44556600, 32);
    chk("post_rst_vals", 32'(nval0 - v), 1);
    chk("post_rst_left", 32'(u0_rl), 32'h0F1E2D);
    chk("post_rst_right", 32'(u0_rr), 32'h3C4B5A);
    chk("post_rst_und", 32'(nund0 - u), 2);
    bypass = 1;
    v = nval0;
    for (int f = 0; f < 3; f++) begin
      bl[f] = $urandom;
      br[f] = $urandom;
      frame(bl[f], br[f], 32);
    end
    bypass = 0;
    chk("bypass_vals", 32'(nval0 - v), 3);
    chk("bypass_rx_left", 32'(u0_rl), 32'(bl[1][31:8]));
    chk("bypass_rx_right", 32'(u0_rr), 32'(br[1][31:8]));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
